debug_unit: RTL
===============

# debug_unit

Host-side debug controller for the MIPS pipeline. It receives command bytes from a UART receiver and loads program words into instruction memory over the IF write port. It controls pipeline advance in run and single-step modes. It serializes a 304-bit snapshot of the MIPS debug outputs (segment registers, control registers, PC) to a UART transmitter. It sits between the UART RX/TX pair and the MIPS top, and drives the MIPS load/step inputs while consuming the MIPS debug outputs.

## Interface
- `NB_INST_ADDR`, 8: instruction write address width.
- `RUN_TIMEOUT`, 1000000: run-mode cycle limit; used only when the Configuration macro is defined.
- `clk` input 1: single system clock.
- `i_reset` input 1: synchronous, active-high reset.
- `i_rx_data` input 8: byte from the UART receiver.
- `i_rx_valid` input 1: one-cycle strobe; `i_rx_data` is valid.
- `i_tx_done` input 1: one-cycle strobe from the transmitter; the previous byte has been sent.
- `o_tx_data` output 8: byte to transmit.
- `o_tx_start` output 1: one-cycle strobe that launches `o_tx_data`.
- `o_we_IF` output 1: instruction-memory write enable, one cycle per word.
- `o_instruction_data` output 32: instruction word to write.
- `o_instruction_addr` output NB_INST_ADDR: word write address.
- `o_mips_reset` output 1: reset to the MIPS core, one-cycle pulse.
- `o_step` output 1: pipeline hold. 1 = frozen, 0 = the pipeline advances that cycle.
- `i_id_ex` input 144, `i_ex_mem` input 32, `i_mem_wb` input 48, `i_wb_id` input 40, `i_ctrl_id_ex` input 24, `i_pc_lsb` input 16: MIPS debug outputs.
- `i_end` input 1: the MIPS program has halted.

## Operation
- Command codes:
  - 0x4C `L`: load.
  - 0x53 `S`: step.
  - 0x52 `R`: run.
  - 0x44 `D`: dump.
  - Any other byte received in IDLE is discarded.
- FSM states: IDLE, LD_CNT, LD_BYTE, LD_WR, STEP, RUN, DUMP_LATCH, DUMP_SEND, DUMP_WAIT.
- Load:
  - `L` in IDLE → LD_CNT, and `o_mips_reset` pulses for one cycle.
  - The next byte is the word count N. If N=0, return to IDLE.
  - Otherwise collect bytes MSB-first into a 32-bit assembly register. On every 4th byte → LD_WR.
  - LD_WR drives `o_we_IF`=1 for exactly one cycle with the assembled word and the current address. The address then increments and wraps from 0xFF to 0x00.
  - After N words → IDLE. The write address restarts at 0 on every `L`.
- Step: `S` → STEP. `o_step`=0 for exactly one cycle, then → DUMP_LATCH.
- Run: `R` → RUN. `o_step`=0 until `i_end` is sampled 1; `o_step` is 1 in that same cycle. Then → DUMP_LATCH.
- Dump: `D` → DUMP_LATCH without advancing the pipeline.
- Frame content: DUMP_LATCH captures, in one cycle, the concatenation {i_id_ex, i_ex_mem, i_mem_wb, i_wb_id, i_ctrl_id_ex, i_pc_lsb}. That is 304 bits = 38 bytes.
- Frame transmission:
  - DUMP_SEND emits the next byte, most significant first, with `o_tx_start` high for one cycle, then → DUMP_WAIT.
  - DUMP_WAIT holds until `i_tx_done`, then returns to DUMP_SEND.
  - After byte 38, → IDLE.
- `i_rx_valid` is ignored in every state except IDLE, LD_CNT and LD_BYTE.

## Timing
- Reset values:
  - `o_step`=1.
  - All other outputs 0.
  - FSM in IDLE; byte, word and frame counters all 0.
- Reset mid-operation aborts the operation:
  - Any partial frame is abandoned; no further `o_tx_start`.
  - A partial word is discarded.
- Latencies:
  - `i_rx_valid` of the 4th byte of a word → `o_we_IF` one cycle later.
  - `S` accepted → `o_step` low in the next cycle → first `o_tx_start` 2 cycles after that low cycle.
  - `i_tx_done` → next `o_tx_start` 1 cycle later (one cycle in DUMP_SEND).
- Run boundary: if `i_end` is already 1 when `R` is accepted, `o_step` never drops and the dump starts immediately.
- Simultaneous `i_tx_done` and `i_rx_valid` in DUMP_WAIT: the byte is dropped and the frame continues.
- `o_instruction_data` and `o_instruction_addr` hold their last values outside LD_WR.

## Configuration
- `DEBUG_UNIT_RUN_TIMEOUT_EN`
  - Defined: a run counter counts RUN cycles. When it reaches `RUN_TIMEOUT` before `i_end`, `o_step` returns to 1 and the frame is dumped, followed by one extra byte 0xEE (39 bytes total). After a normal `i_end` exit, the extra byte is 0x00.
  - Undefined: RUN waits for `i_end` indefinitely, and the frame is exactly 38 bytes. No counter logic is synthesized.

## Structure
- Package `debug_unit_pkg` holds:
  - the command code constants;
  - the frame width (304) and byte count (38);
  - the timeout marker 0xEE;
  - the FSM state enum.
- Sub-module `debug_frame_tx` holds the frame serializer:
  - a 304-bit shift register loaded on latch;
  - a byte counter;
  - the `o_tx_start`/`i_tx_done` handshake;
  - a done flag back to the FSM.

## Test plan
- Load N=2: send `L`, 0x02, then 12 34 56 78 AA BB CC DD → `o_we_IF` pulses twice. First write is 0x12345678 at addr 0; second is 0xAABBCCDD at addr 1. `o_mips_reset` pulses once.
- Dump: drive `i_pc_lsb`=0xBEEF and `i_id_ex`[143:136]=0xA5, send `D` → 38 `o_tx_start` strobes. Byte 0 is 0xA5, byte 36 is 0xBE, byte 37 is 0xEF. `o_step` stays 1 throughout.
- Step: send `S` → exactly one cycle with `o_step`=0, then a 38-byte frame. A second `S` sent during the frame is ignored.
- Run: send `R` and raise `i_end` 20 cycles later → `o_step`=0 for 20 cycles, then a dump. With `i_end` already 1 when `R` is sent → zero advance cycles.
- Reset during the frame: assert `i_reset` after byte 10 → no further strobes, `o_step`=1, state IDLE. A subsequent `D` sends a full 38 bytes.
- Timeout, with the macro defined and `RUN_TIMEOUT`=100: `R` with `i_end`=0 → 100 advance cycles, then 39 bytes, the last being 0xEE.

Source files
------------

// File: rtl/debug_unit_pkg.sv
// debug_unit_pkg: command codes, frame geometry and FSM state encoding shared
// by the debug controller and its frame serializer.
package debug_unit_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  localparam int FRAME_W     = 304;
  localparam int FRAME_BYTES = 38;

  // Trailer byte marking a run that ended on the cycle limit instead of i_end.
  localparam logic [7:0] TIMEOUT_MARK = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_CNT,
    ST_LD_BYTE,
    ST_LD_WR,
    ST_STEP,
    ST_RUN,
    ST_DUMP_LATCH,
    ST_DUMP_SEND,
    ST_DUMP_WAIT
  } state_t;

endpackage

// File: rtl/debug_unit_if.sv
// debug_unit_if: UART byte handshake plus the instruction-memory write port.
// master = debug controller side, slave = UART / instruction memory side.
interface debug_unit_if #(
  parameter int NB_INST_ADDR = 8
) ();

  logic [7:0]              i_rx_data;
  logic                    i_rx_valid;
  logic                    i_tx_done;
  logic [7:0]              o_tx_data;
  logic                    o_tx_start;
  logic                    o_we_IF;
  logic [31:0]             o_instruction_data;
  logic [NB_INST_ADDR-1:0] o_instruction_addr;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_done,
    output o_tx_data, o_tx_start, o_we_IF, o_instruction_data, o_instruction_addr
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_done,
    input  o_tx_data, o_tx_start, o_we_IF, o_instruction_data, o_instruction_addr
  );

endinterface

// File: rtl/debug_frame_tx.sv
// debug_frame_tx: serializes a latched snapshot MSB byte first. The controller
// strobes i_send once per byte; this block tracks the outstanding byte and
// reports whether the transmitter's done strobe closes the frame or asks for
// the next byte.
module debug_frame_tx
  import debug_unit_pkg::*;
#(
  parameter int N_BYTES = FRAME_BYTES
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_latch,
  input  logic                 i_send,
  input  logic                 i_tx_done,
  input  logic [N_BYTES*8-1:0] i_frame,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_next,
  output logic                 o_done
);

  localparam int NB_CNT = $clog2(N_BYTES + 1);
  localparam int W      = N_BYTES * 8;
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(N_BYTES);

  logic [W-1:0]      r_shift;
  logic [NB_CNT-1:0] r_sent;
  logic              r_busy;
  logic              w_ack;

  assign o_tx_data  = r_shift[W-1 -: 8];
  assign o_tx_start = i_send;
  assign w_ack      = r_busy & i_tx_done;
  assign o_done     = w_ack & (r_sent == LAST_CNT);
  assign o_next     = w_ack & (r_sent != LAST_CNT);

  // Shift register, sent-byte counter and outstanding-byte flag.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_sent  <= '0;
      r_busy  <= 1'b0;
    end else if (i_latch) begin
      r_shift <= i_frame;
      r_sent  <= '0;
      r_busy  <= 1'b0;
    end else if (i_send) begin
      r_shift <= {r_shift[W-9:0], 8'h00};
      r_sent  <= r_sent + 1'b1;
      r_busy  <= 1'b1;
    end else if (i_tx_done) begin
      r_busy  <= 1'b0;
    end
  end

endmodule

// File: rtl/debug_unit.sv
// debug_unit: host debug controller for the MIPS pipeline. Decodes UART
// commands, loads program words, gates pipeline advance for step/run and
// dumps a 304-bit debug snapshot back over the UART.
// Optional feature macro: DEBUG_UNIT_RUN_TIMEOUT_EN (run-cycle limit plus a
// trailing status byte, 0xEE on timeout / 0x00 otherwise).
//
// state          | meaning
// ST_IDLE        | waiting for a command byte
// ST_LD_CNT      | waiting for the word count of a load
// ST_LD_BYTE     | collecting instruction bytes, MSB first
// ST_LD_WR       | one-cycle instruction-memory write
// ST_STEP        | single pipeline advance cycle
// ST_RUN         | pipeline advancing until i_end (or timeout)
// ST_DUMP_LATCH  | capture the debug snapshot
// ST_DUMP_SEND   | launch one frame byte
// ST_DUMP_WAIT   | wait for the transmitter to finish the byte
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int NB_INST_ADDR = 8,
  parameter int RUN_TIMEOUT  = 1000000
) (
  input  logic           clk,
  input  logic           i_reset,
  debug_unit_if.master   bus,
  output logic           o_mips_reset,
  output logic           o_step,
  input  logic [143:0]   i_id_ex,
  input  logic [31:0]    i_ex_mem,
  input  logic [47:0]    i_mem_wb,
  input  logic [39:0]    i_wb_id,
  input  logic [23:0]    i_ctrl_id_ex,
  input  logic [15:0]    i_pc_lsb,
  input  logic           i_end
);

`ifdef DEBUG_UNIT_RUN_TIMEOUT_EN
  localparam int N_TX_BYTES = FRAME_BYTES + 1;
`else
  localparam int N_TX_BYTES = FRAME_BYTES;
`endif

  state_t                  r_state;
  state_t                  w_state_next;
  logic [7:0]              r_words_left;
  logic [1:0]              r_byte_cnt;
  logic [23:0]             r_asm;
  logic [NB_INST_ADDR-1:0] r_addr;
  logic [NB_INST_ADDR-1:0] r_inst_addr;
  logic [31:0]             r_inst_data;
  logic                    r_mips_reset;

  logic                    w_load_start;
  logic                    w_run_start;
  logic                    w_latch;
  logic                    w_send;
  logic                    w_we;
  logic                    w_step;
  logic                    w_timeout;
  logic                    w_tx_next;
  logic                    w_tx_done;
  logic [7:0]              w_tx_data;
  logic                    w_tx_start;
  logic [FRAME_W-1:0]      w_frame;
  logic [N_TX_BYTES*8-1:0] w_tx_frame;

  assign w_frame = {i_id_ex, i_ex_mem, i_mem_wb, i_wb_id, i_ctrl_id_ex, i_pc_lsb};

`ifdef DEBUG_UNIT_RUN_TIMEOUT_EN
  logic [31:0] r_run_cnt;
  logic        r_timed_out;

  assign w_timeout  = (r_state == ST_RUN) && !i_end && (r_run_cnt == 32'd1);
  assign w_tx_frame = {w_frame, (r_timed_out ? TIMEOUT_MARK : 8'h00)};

  // Run-cycle down-counter; the timeout flag selects the frame trailer.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_run_cnt   <= '0;
      r_timed_out <= 1'b0;
    end else if (w_run_start) begin
      r_run_cnt   <= 32'(RUN_TIMEOUT);
      r_timed_out <= 1'b0;
    end else if (r_state == ST_IDLE && bus.i_rx_valid) begin
      r_timed_out <= 1'b0;
    end else if (r_state == ST_RUN && !i_end) begin
      r_run_cnt <= r_run_cnt - 32'd1;
      if (w_timeout) r_timed_out <= 1'b1;
    end
  end
`else
  assign w_timeout  = 1'b0;
  assign w_tx_frame = w_frame;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next state and per-state control strobes.
  always_comb begin
    w_state_next = r_state;
    w_load_start = 1'b0;
    w_run_start  = 1'b0;
    w_latch      = 1'b0;
    w_send       = 1'b0;
    w_we         = 1'b0;
    w_step       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_rx_valid) begin
          case (bus.i_rx_data)
            CMD_LOAD: begin
              w_load_start = 1'b1;
              w_state_next = ST_LD_CNT;
            end
            CMD_STEP: w_state_next = ST_STEP;
            CMD_RUN: begin
              // A core that has already halted gets dumped without advancing.
              w_run_start  = 1'b1;
              w_state_next = i_end ? ST_DUMP_LATCH : ST_RUN;
            end
            CMD_DUMP: w_state_next = ST_DUMP_LATCH;
            default:  w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_LD_CNT: begin
        if (bus.i_rx_valid) w_state_next = (bus.i_rx_data == 8'h00) ? ST_IDLE : ST_LD_BYTE;
      end
      ST_LD_BYTE: begin
        if (bus.i_rx_valid && r_byte_cnt == 2'd3) w_state_next = ST_LD_WR;
      end
      ST_LD_WR: begin
        w_we         = 1'b1;
        w_state_next = (r_words_left == 8'd1) ? ST_IDLE : ST_LD_BYTE;
      end
      ST_STEP: begin
        w_step       = 1'b0;
        w_state_next = ST_DUMP_LATCH;
      end
      ST_RUN: begin
        if (i_end) begin
          w_state_next = ST_DUMP_LATCH;
        end else begin
          w_step = 1'b0;
          if (w_timeout) w_state_next = ST_DUMP_LATCH;
        end
      end
      ST_DUMP_LATCH: begin
        w_latch      = 1'b1;
        w_state_next = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        w_send       = 1'b1;
        w_state_next = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (w_tx_done)      w_state_next = ST_IDLE;
        else if (w_tx_next) w_state_next = ST_DUMP_SEND;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Load datapath: word assembly, write address and remaining word count.
  // The write port registers only change on a completed word so they hold
  // their last value outside the write cycle.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_words_left <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_addr       <= '0;
      r_inst_addr  <= '0;
      r_inst_data  <= '0;
      r_mips_reset <= 1'b0;
    end else begin
      r_mips_reset <= w_load_start;
      case (r_state)
        ST_IDLE: begin
          if (w_load_start) begin
            r_addr     <= '0;
            r_byte_cnt <= '0;
          end
        end
        ST_LD_CNT: begin
          if (bus.i_rx_valid) begin
            r_words_left <= bus.i_rx_data;
            r_byte_cnt   <= '0;
          end
        end
        ST_LD_BYTE: begin
          if (bus.i_rx_valid) begin
            r_asm      <= {r_asm[15:0], bus.i_rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_inst_data <= {r_asm, bus.i_rx_data};
              r_inst_addr <= r_addr;
            end
          end
        end
        ST_LD_WR: begin
          r_addr       <= r_addr + 1'b1;
          r_words_left <= r_words_left - 8'd1;
        end
        default: ;
      endcase
    end
  end

  debug_frame_tx #(
    .N_BYTES (N_TX_BYTES)
  ) u_frame_tx (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_latch    (w_latch),
    .i_send     (w_send),
    .i_tx_done  (bus.i_tx_done),
    .i_frame    (w_tx_frame),
    .o_tx_data  (w_tx_data),
    .o_tx_start (w_tx_start),
    .o_next     (w_tx_next),
    .o_done     (w_tx_done)
  );

  assign bus.o_tx_data          = w_tx_data;
  assign bus.o_tx_start         = w_tx_start;
  assign bus.o_we_IF            = w_we;
  assign bus.o_instruction_data = r_inst_data;
  assign bus.o_instruction_addr = r_inst_addr;
  assign o_mips_reset           = r_mips_reset;
  assign o_step                 = w_step;

endmodule
